tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
//
// PURPOSE
//   Multi-channel periodic event scheduler driven by the shared 1-cycle tick
//   pulse from the tick generator. Each channel counts ticks down from a
//   programmable period; on expiry it raises a pending request. A round-robin
//   arbiter serialises pending requests onto one valid/ready event port.
//   Sits between the tick generator and consumers (display refresh, debounce,
//   LED/FND update) that share a single periodic time base.
//
// PARAMETERS
//   NUM_CH    4  number of channels (2..16)
//   PERIOD_W  8  period/counter width in ticks
//   CH_W      $clog2(NUM_CH), derived localparam, not overridable
//
// PORTS
//   clk         in   1               system clock, 100 MHz
//   reset       in   1               asynchronous reset, active-low
//   tick        in   1               1-cycle time-base pulse
//   ch_en       in   NUM_CH          per-channel enable, level
//   cfg_we      in   1               config write strobe, 1 cycle
//   cfg_ch      in   CH_W            channel index for cfg write
//   cfg_period  in   PERIOD_W        period in ticks; 0 = channel never fires
//   evt_valid   out  1               event available
//   evt_ch      out  CH_W            channel of presented event
//   evt_ready   in   1               consumer accepts event
//   overrun     out  NUM_CH          sticky: expiry while already pending
//   ovr_clr     in   NUM_CH          clear overrun bits, 1 cycle
//
// BEHAVIOUR
//   - Reset (reset=0, async):
//     - period[*]=0, cnt[*]=0, pending=0, overrun=0.
//     - evt_valid=0, evt_ch=0, rr pointer=0.
//   - Counter, per channel, on each clk edge:
//     - cfg_we && cfg_ch==i: period[i]<=cfg_period, cnt[i]<=cfg_period.
//       Config wins over a same-cycle tick; pending[i] is unaffected.
//     - else !ch_en[i]: cnt[i]<=period[i], pending[i]<=0, except the channel
//       currently latched in evt_ch while evt_valid=1.
//     - else tick && period[i]!=0:
//       - cnt[i]==1: expiry; cnt[i]<=period[i], pending[i]<=1.
//       - otherwise cnt[i]<=cnt[i]-1.
//     - Expiry interval is exactly period[i] ticks; period=1 fires every tick.
//   - Overrun:
//     - Expiry while pending[i]=1 and not being handshaken that cycle sets
//       overrun[i]. The event is merged, not queued.
//     - ovr_clr[i] clears overrun[i]; a same-cycle set wins.
//   - Arbiter/handshake:
//     - When evt_valid=0 and pending!=0: on the next edge latch evt_ch = first
//       pending channel at or after rr pointer (wrapping); evt_valid<=1.
//     - Latency: tick -> pending is 1 clk; pending -> evt_valid is 1 clk.
//     - evt_ch stays stable while evt_valid && !evt_ready.
//     - evt_valid && evt_ready:
//       - clear pending[evt_ch], rr<=evt_ch+1 (mod NUM_CH), evt_valid<=0.
//       - If the same channel expires in that cycle, pending re-sets and no
//         overrun is flagged.
//     - At most one event per 2 clk; 1 idle cycle between events is required.
//   - Widths: cfg_ch >= NUM_CH is ignored. All arithmetic is unsigned, no
//     wrap below 0.
//   - A mid-operation reset drops any presented event immediately
//     (evt_valid=0 asynchronously).
//
// TESTING
//   1. Reset, cfg ch0 period=3, ch_en=0001, ready=1, 10 ticks
//      -> events ch0 after ticks 3, 6, 9; evt_valid 2 clk after tick.
//   2. ch0..3 period=1, all enabled, ready=1, 1 tick
//      -> events in order 0,1,2,3; rr ends at 0; no overrun.
//   3. ch1 period=2, ready=0 held for 6 ticks
//      -> evt_valid=1, evt_ch=1 stable; overrun=0010 after tick 4;
//      ovr_clr=0010 -> 0.
//   4. cfg_we ch2 period=5 on the same cycle as tick, cnt=1
//      -> no expiry; next event 5 ticks later.
//   5. Disable ch3 while pending but not presented -> pending cleared, no
//      event. Disable while presented -> event completes on ready.
//   6. Assert reset mid-handshake (evt_valid=1)
//      -> all outputs 0 immediately; after release no event until a new
//      config and expiry.

Source files
------------

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel periodic tick scheduler with round-robin event port
//
// Purpose: each channel counts shared time-base ticks down from a programmable
// period and raises a pending request on expiry. A round-robin arbiter presents
// one pending channel at a time on a valid/ready event port.
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active-low
//   tick        1-cycle time-base pulse
//   ch_en       per-channel enable (level)
//   cfg_we      config write strobe
//   cfg_ch      channel index for config write (out-of-range ignored)
//   cfg_period  period in ticks, 0 = channel never fires
//   evt_valid   event available
//   evt_ch      channel of presented event
//   evt_ready   consumer accepts event
//   overrun     sticky per-channel flag: expiry while already pending
//   ovr_clr     per-channel overrun clear pulse
module tick_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 8,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                evt_valid,
    output logic [CH_W-1:0]     evt_ch,
    input  logic                evt_ready,
    output logic [NUM_CH-1:0]   overrun,
    input  logic [NUM_CH-1:0]   ovr_clr
);

    logic [PERIOD_W-1:0] r_period [NUM_CH];
    logic [PERIOD_W-1:0] r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   r_overrun;
    logic                r_evt_valid;
    logic [CH_W-1:0]     r_evt_ch;
    logic [CH_W-1:0]     r_rr;

    logic                w_hs;
    logic [NUM_CH-1:0]   w_cfg_hit;
    logic [NUM_CH-1:0]   w_held;
    logic [NUM_CH-1:0]   w_ack;
    logic [NUM_CH-1:0]   w_expire;
    logic [NUM_CH-1:0]   w_pending_nxt;
    logic [NUM_CH-1:0]   w_overrun_nxt;
    logic [CH_W-1:0]     w_pick_hi;
    logic [CH_W-1:0]     w_pick_lo;
    logic                w_pick_hi_found;
    logic [CH_W-1:0]     w_pick;

    assign w_hs      = r_evt_valid && evt_ready;
    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign overrun   = r_overrun;

    // Per-channel decode. An out-of-range cfg_ch matches no channel, so it is
    // dropped without any extra range check.
    always_comb begin
        w_cfg_hit     = '0;
        w_held        = '0;
        w_ack         = '0;
        w_expire      = '0;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
            w_held[i]    = r_evt_valid && (r_evt_ch == CH_W'(i));
            w_ack[i]     = w_hs && w_held[i];
            // A config write takes precedence over a same-cycle tick.
            w_expire[i]  = !w_cfg_hit[i] && ch_en[i] && tick &&
                           (r_period[i] != '0) && (r_cnt[i] == PERIOD_W'(1));

            // Handshake clears the request, but a same-cycle expiry re-arms it.
            if (w_ack[i])
                w_pending_nxt[i] = w_expire[i];
            else if (w_expire[i])
                w_pending_nxt[i] = 1'b1;
            else if (!w_cfg_hit[i] && !ch_en[i] && !w_held[i])
                w_pending_nxt[i] = 1'b0;

            // Set beats clear; an expiry merged into an accepted event is not an overrun.
            w_overrun_nxt[i] = (w_expire[i] && r_pending[i] && !w_ack[i]) ||
                               (r_overrun[i] && !ovr_clr[i]);
        end
    end

    // Round-robin pick: lowest pending index at or above r_rr, otherwise wrap
    // to the lowest pending index overall. Scanning downward leaves the lowest.
    always_comb begin
        w_pick_hi       = '0;
        w_pick_lo       = '0;
        w_pick_hi_found = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (r_pending[j]) begin
                w_pick_lo = CH_W'(j);
                if (j >= int'(r_rr)) begin
                    w_pick_hi       = CH_W'(j);
                    w_pick_hi_found = 1'b1;
                end
            end
        end
        w_pick = w_pick_hi_found ? w_pick_hi : w_pick_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_hit[i]) begin
                    r_period[i] <= cfg_period;
                    r_cnt[i]    <= cfg_period;
                end else if (!ch_en[i]) begin
                    // Disabled channels restart a full period when re-enabled.
                    r_cnt[i] <= r_period[i];
                end else if (tick && (r_period[i] != '0)) begin
                    r_cnt[i] <= w_expire[i] ? r_period[i] : (r_cnt[i] - PERIOD_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Event port. A handshake cycle always drops valid, which guarantees the
    // idle cycle between consecutive events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_rr        <= '0;
        end else if (w_hs) begin
            r_evt_valid <= 1'b0;
            r_rr        <= (r_evt_ch == CH_W'(NUM_CH - 1)) ? '0 : (r_evt_ch + CH_W'(1));
        end else if (!r_evt_valid && (r_pending != '0)) begin
            r_evt_valid <= 1'b1;
            r_evt_ch    <= w_pick;
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam int NUM_CH   = 4;
    localparam int PERIOD_W = 8;
    localparam int CH_W     = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                tick;
    logic [NUM_CH-1:0]   ch_en;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                evt_valid;
    logic [CH_W-1:0]     evt_ch;
    logic                evt_ready;
    logic [NUM_CH-1:0]   overrun;
    logic [NUM_CH-1:0]   ovr_clr;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: ticks elapsed since the last (re)load, compared against
    // the period; requests and flags kept as plain per-channel bits.
    int m_per  [NUM_CH];
    int m_ts   [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_ovr  [NUM_CH];
    bit m_valid;
    int m_ch;
    int m_rr;
    int hs_cnt [NUM_CH];
    int hs_order [$];

    tick_scheduler #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .reset(reset), .tick(tick), .ch_en(ch_en),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_ready(evt_ready),
        .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ovr_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_ovr[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_per[i] = 0; m_ts[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end
        m_valid = 0; m_ch = 0; m_rr = 0;
    endtask

    task automatic clear_tally();
        for (int i = 0; i < NUM_CH; i++) hs_cnt[i] = 0;
        hs_order.delete();
    endtask

    task automatic model_step();
        bit hs;
        bit n_pend [NUM_CH];
        if (!reset) begin
            model_reset();
            return;
        end
        hs = m_valid && evt_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            bit fire;
            bit mine;
            bit cfg_hit;
            fire    = 0;
            mine    = m_valid && (m_ch == i);
            cfg_hit = cfg_we && (int'(cfg_ch) == i);
            n_pend[i] = m_pend[i];
            if (cfg_hit) begin
                m_per[i] = int'(cfg_period);
                m_ts[i]  = 0;
            end else if (!ch_en[i]) begin
                m_ts[i] = 0;
                if (!mine) n_pend[i] = 0;
            end else if (tick && m_per[i] != 0) begin
                m_ts[i]++;
                if (m_ts[i] == m_per[i]) begin
                    fire    = 1;
                    m_ts[i] = 0;
                end
            end
            if (hs && mine) n_pend[i] = fire;
            else if (fire) n_pend[i] = 1;
            if (fire && m_pend[i] && !(hs && mine)) m_ovr[i] = 1;
            else if (ovr_clr[i]) m_ovr[i] = 0;
        end
        if (hs) begin
            hs_cnt[m_ch]++;
            hs_order.push_back(m_ch);
            m_valid = 0;
            m_rr    = (m_ch + 1) % NUM_CH;
        end else if (!m_valid) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_rr + k) % NUM_CH;
                if (m_pend[c]) begin
                    m_valid = 1;
                    m_ch    = c;
                    break;
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) m_pend[i] = n_pend[i];
    endtask

    // One clock: model follows the edge, outputs checked 1 ns later, pulses dropped.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_ch", 32'(evt_ch), 32'(m_ch));
        chk("overrun", 32'(overrun), ovr_vec());
        tick    = 1'b0;
        cfg_we  = 1'b0;
        ovr_clr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        ch_en = '0; evt_ready = 1'b0; ovr_clr = '0;
        #1;
        model_reset();
        clear_tally();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ch", 32'(evt_ch), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic cfg(input int ch, input int per);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = PERIOD_W'(per);
        cyc();
    endtask

    initial begin
        #2;
        // 1: period 3, events after ticks 3, 6, 9, valid 2 clk after the tick
        do_reset();
        ch_en = 4'b0001; evt_ready = 1'b1;
        cfg(0, 3);
        for (int t = 1; t <= 10; t++) begin
            tick = 1'b1;
            cyc();
            cyc();
            chk("s1_lat", 32'(evt_valid), (t % 3 == 0) ? 32'd1 : 32'd0);
            cyc();
            cyc();
        end
        chk("s1_count", 32'(hs_cnt[0]), 32'd3);

        // 2: all channels period 1, one tick, served in order 0..3
        do_reset();
        for (int c = 0; c < NUM_CH; c++) cfg(c, 1);
        ch_en = 4'b1111; evt_ready = 1'b1;
        tick = 1'b1;
        repeat (12) cyc();
        chk("s2_n", 32'(hs_order.size()), 32'd4);
        if (hs_order.size() == 4)
            for (int k = 0; k < 4; k++) chk("s2_order", 32'(hs_order[k]), 32'(k));
        chk("s2_ovr", 32'(overrun), 32'd0);

        // 3: consumer stalled, event held, overrun after tick 4, then cleared
        do_reset();
        ch_en = 4'b0010; evt_ready = 1'b0;
        cfg(1, 2);
        for (int t = 1; t <= 6; t++) begin
            tick = 1'b1;
            cyc();
            if (t == 4) chk("s3_ovr", 32'(overrun), 32'h2);
            if (t == 3) chk("s3_no_ovr", 32'(overrun), 32'h0);
            cyc();
        end
        chk("s3_hold_v", 32'(evt_valid), 32'd1);
        chk("s3_hold_ch", 32'(evt_ch), 32'd1);
        ovr_clr = 4'b0010;
        cyc();
        chk("s3_clr", 32'(overrun), 32'h0);
        evt_ready = 1'b1;
        repeat (4) cyc();

        // 4: reconfigure on the tick that would have expired
        do_reset();
        ch_en = 4'b0100; evt_ready = 1'b1;
        cfg(2, 2);
        tick = 1'b1;
        cyc();
        cyc();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 8'd5; tick = 1'b1;
        cyc();
        cyc();
        chk("s4_no_exp", 32'(evt_valid), 32'd0);
        for (int t = 1; t <= 5; t++) begin
            tick = 1'b1;
            cyc();
            cyc();
            chk("s4_exp", 32'(evt_valid), (t == 5) ? 32'd1 : 32'd0);
        end
        repeat (3) cyc();

        // 5: disable pending ch3 (dropped) and presented ch2 (completes)
        do_reset();
        evt_ready = 1'b0;
        cfg(2, 1);
        cfg(3, 1);
        ch_en = 4'b1100;
        tick = 1'b1;
        cyc();
        cyc();
        chk("s5_pres", 32'(evt_ch), 32'd2);
        ch_en = 4'b0000;
        repeat (2) cyc();
        evt_ready = 1'b1;
        repeat (6) cyc();
        chk("s5_ch2", 32'(hs_cnt[2]), 32'd1);
        chk("s5_ch3", 32'(hs_cnt[3]), 32'd0);

        // 6: reset while an event is presented
        do_reset();
        evt_ready = 1'b0;
        ch_en = 4'b0001;
        cfg(0, 1);
        tick = 1'b1;
        cyc();
        cyc();
        chk("s6_pre", 32'(evt_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("s6_async_v", 32'(evt_valid), 32'd0);
        chk("s6_async_o", 32'(overrun), 32'd0);
        model_reset();
        clear_tally();
        cyc();
        reset = 1'b1;
        evt_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick = 1'b1;
            cyc();
            cyc();
        end
        chk("s6_quiet", 32'(hs_order.size()), 32'd0);

        // Randomised traffic against the model
        do_reset();
        ch_en = 4'b1111;
        for (int n = 0; n < 3000; n++) begin
            tick      = ($urandom_range(0, 2) == 0);
            evt_ready = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 19) == 0) begin
                cfg_we     = 1'b1;
                cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
                cfg_period = PERIOD_W'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) ovr_clr = NUM_CH'($urandom_range(0, 15));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
